// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one T flip-flop among N_REQ requesters.
// Each accepted request produces a one-cycle grant/toggle, followed by a COOL-cycle hold-off.
module tff_toggle_arbiter #(
   parameter int N_REQ = 4,
   parameter int COOL  = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             tff_en,
   output logic             q,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic             busy
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [3:0] COOL_M1 = (COOL > 0) ? 4'(COOL - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COOL} state_t;

   state_t            r_state, w_state_nxt;
   logic [N_REQ-1:0]  r_gnt;
   logic [PW-1:0]     r_ptr, r_gidx, w_sel_idx;
   logic              w_sel_vld;
   logic [3:0]        r_cool;
   logic              r_q;
   logic [CNT_W-1:0]  r_cnt;
   int                w_k;

   // Rotating priority: first set request bit at or after r_ptr, wrapping.
   always_comb begin
      w_sel_vld = 1'b0;
      w_sel_idx = '0;
      w_k       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         w_k = int'(r_ptr) + i;
         if (w_k >= N_REQ) w_k = w_k - N_REQ;
         if (!w_sel_vld && req[w_k]) begin
            w_sel_vld = 1'b1;
            w_sel_idx = PW'(w_k);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_sel_vld) w_state_nxt = S_GRANT;
         S_GRANT: w_state_nxt = (COOL > 0) ? S_COOL : S_IDLE;
         S_COOL:  if (r_cool == 4'd0) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_gidx  <= '0;
         r_ptr   <= '0;
         r_cool  <= '0;
         r_q     <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_sel_vld) begin
                  r_gnt  <= N_REQ'(1) << w_sel_idx;
                  r_gidx <= w_sel_idx;
               end
            end
            S_GRANT: begin
               r_gnt  <= '0;
               r_q    <= ~r_q;
               r_cnt  <= r_cnt + 1'b1;
               r_ptr  <= (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
               r_cool <= COOL_M1;
            end
            S_COOL: begin
               if (r_cool != 4'd0) r_cool <= r_cool - 1'b1;
            end
            default: r_gnt <= '0;
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign tff_en     = |r_gnt;
   assign q          = r_q;
   assign toggle_cnt = r_cnt;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Randomized and directed checks of tff_toggle_arbiter against a request/hold-off model.
module tb_tff_toggle_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       tff_en, q, busy;
   logic [7:0] cnt;

   logic       rst_w_n;
   logic [3:0] req_w;
   logic [3:0] gnt_w;
   logic       tff_en_w, q_w, busy_w;
   logic [3:0] cnt_w;

   int checks = 0;
   int errors = 0;

   // model: granted index (-1 none), hold-off cycles remaining, pointer, q, count
   int m_idx, m_wait, m_ptr, m_cnt;
   bit m_q;

   always #5 clk = ~clk;

   tff_toggle_arbiter #(.N_REQ(4), .COOL(2), .CNT_W(8)) dut (
      .clk(clk), .reset(rst_n), .req(req), .gnt(gnt), .tff_en(tff_en),
      .q(q), .toggle_cnt(cnt), .busy(busy));

   tff_toggle_arbiter #(.N_REQ(4), .COOL(0), .CNT_W(4)) dut_w (
      .clk(clk), .reset(rst_w_n), .req(req_w), .gnt(gnt_w), .tff_en(tff_en_w),
      .q(q_w), .toggle_cnt(cnt_w), .busy(busy_w));

   function automatic logic [3:0] exp_gnt();
      return (m_idx >= 0) ? 4'(1 << m_idx) : 4'b0000;
   endfunction

   function automatic logic [14:0] exp_vec();
      return {exp_gnt(), (m_idx >= 0), m_q, 8'(m_cnt), (m_idx >= 0 || m_wait > 0)};
   endfunction

   // Advance one clock; model sees the same req/reset the DUT samples at that edge.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         m_idx = -1; m_wait = 0; m_ptr = 0; m_q = 0; m_cnt = 0;
      end else if (m_idx >= 0) begin
         m_q    = ~m_q;
         m_cnt  = (m_cnt + 1) % 256;
         m_ptr  = (m_idx + 1) % 4;
         m_idx  = -1;
         m_wait = 2;
      end else if (m_wait > 0) begin
         m_wait--;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (req[(m_ptr + i) % 4]) begin
               m_idx = (m_ptr + i) % 4;
               break;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({gnt, tff_en, q, cnt, busy} !== 15'd0) begin
            errors++;
            $display("FAIL reset: got gnt=%b en=%b q=%b cnt=%0d busy=%b, want all zero",
                     gnt, tff_en, q, cnt, busy);
         end
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (gnt !== 4'b0001 || tff_en !== 1'b1) begin
         errors++;
         $display("FAIL first_grant: got gnt=%b en=%b, want 0001 1", gnt, tff_en);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] want [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] seen [$];
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 24; c++) begin
         tick();
         checks++;
         if ({gnt, tff_en, q, cnt, busy} !== exp_vec()) begin
            errors++;
            $display("FAIL rr_cycle%0d: got %b want %b", c, {gnt, tff_en, q, cnt, busy}, exp_vec());
         end
         if (gnt != 4'b0000) seen.push_back(gnt);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= seen.size() || seen[i] !== want[i]) begin
            errors++;
            $display("FAIL rr_order%0d: got %b want %b", i,
                     (i < seen.size()) ? seen[i] : 4'bxxxx, want[i]);
         end
      end
   endtask

   task automatic test_single();
      int ng = 0;
      int last = -1;
      do_reset();
      req = 4'b0100;
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++;
         if ({gnt, tff_en, q, cnt, busy} !== exp_vec()) begin
            errors++;
            $display("FAIL single_cycle%0d: got %b want %b", c, {gnt, tff_en, q, cnt, busy}, exp_vec());
         end
         if (gnt == 4'b0100) begin
            if (last >= 0) begin
               checks++;
               if (c - last != 4) begin
                  errors++;
                  $display("FAIL single_period: got %0d want 4", c - last);
               end
            end
            last = c;
            ng++;
            if (ng == 5) begin
               tick();
               checks++;
               if (cnt !== 8'd5 || q !== 1'b1) begin
                  errors++;
                  $display("FAIL single_five: got cnt=%0d q=%b want 5 1", cnt, q);
               end
               break;
            end
         end
      end
      checks++;
      if (ng != 5) begin
         errors++;
         $display("FAIL single_count: got %0d grants want 5", ng);
      end
   endtask

   task automatic test_ptr_skip();
      logic [3:0] seen [$];
      bit armed = 0;
      do_reset();
      req = 4'b0010;
      for (int c = 0; c < 40 && seen.size() < 2; c++) begin
         tick();
         checks++;
         if ({gnt, tff_en, q, cnt, busy} !== exp_vec()) begin
            errors++;
            $display("FAIL skip_cycle%0d: got %b want %b", c, {gnt, tff_en, q, cnt, busy}, exp_vec());
         end
         if (armed && gnt != 4'b0000) begin
            seen.push_back(gnt);
            req = req & ~gnt;
         end
         if (!armed && gnt == 4'b0010) begin
            armed = 1;
            req   = 4'b1010;
         end
      end
      checks++;
      if (seen.size() != 2 || seen[0] !== 4'b1000 || seen[1] !== 4'b0010) begin
         errors++;
         $display("FAIL skip_order: got %0d grants first=%b second=%b want 1000 0010", seen.size(),
                  (seen.size() > 0) ? seen[0] : 4'bxxxx, (seen.size() > 1) ? seen[1] : 4'bxxxx);
      end
   endtask

   task automatic test_reset_mid();
      bit hit = 0;
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (gnt == 4'b0001 && q == 1'b1) begin
            hit   = 1;
            rst_n = 1'b0;
            req   = 4'b0000;
            tick();
            checks++;
            if ({gnt, tff_en, q, cnt, busy} !== 15'd0) begin
               errors++;
               $display("FAIL reset_mid: got gnt=%b q=%b cnt=%0d busy=%b want 0", gnt, q, cnt, busy);
            end
            rst_n = 1'b1;
            tick();
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
               errors++;
               $display("FAIL reset_mid_idle: got gnt=%b busy=%b want 0000 0", gnt, busy);
            end
            break;
         end
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL reset_mid_timeout: got no grant with q=1, want one");
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         rst_n = ($urandom_range(0, 60) != 0);
         tick();
         checks++;
         if ({gnt, tff_en, q, cnt, busy} !== exp_vec()) begin
            errors++;
            $display("FAIL random_cycle%0d: got %b want %b", c, {gnt, tff_en, q, cnt, busy}, exp_vec());
         end
         if ($countones(gnt) > 1) begin
            errors++;
            $display("FAIL random_onehot: got gnt=%b want at most one bit", gnt);
         end
      end
      rst_n = 1'b1;
      req   = 4'b0000;
   endtask

   task automatic test_wrap();
      int k = 0;
      rst_w_n = 1'b0;
      req_w   = 4'b0000;
      tick();
      tick();
      rst_w_n = 1'b1;
      req_w   = 4'b0001;
      for (int c = 0; c < 200 && k < 16; c++) begin
         tick();
         if (gnt_w == 4'b0001) begin
            tick();
            k++;
            checks++;
            if (cnt_w !== 4'(k % 16) || q_w !== 1'(k % 2)) begin
               errors++;
               $display("FAIL wrap_step%0d: got cnt=%0d q=%b want %0d %0d", k, cnt_w, q_w, k % 16, k % 2);
            end
         end
      end
      req_w = 4'b0000;
      checks++;
      if (k != 16 || cnt_w !== 4'd0 || q_w !== 1'b0) begin
         errors++;
         $display("FAIL wrap_end: got toggles=%0d cnt=%0d q=%b want 16 0 0", k, cnt_w, q_w);
      end
   endtask

   initial begin
      m_idx = -1; m_wait = 0; m_ptr = 0; m_q = 0; m_cnt = 0;
      rst_w_n = 1'b0;
      req_w   = 4'b0000;
      test_reset();
      test_round_robin();
      test_single();
      test_ptr_skip();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
